// File: rtl/dice_roll_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : dice_roll_sequencer_if
// Brief  : Random-source handshake and roll-result bundle for the dice roller.
// Rev    : 1.0 - initial release
// ============================================================================
interface dice_roll_sequencer_if #(
  parameter int RND_W = 8
);
  logic             rnd_req;
  logic             rnd_ack;
  logic [RND_W-1:0] rnd_data;
  logic             busy;
  logic             roll_valid;
  logic [4:0]       roll_value;
  logic [4:0]       roll_sides;

  modport master (
    output rnd_req, busy, roll_valid, roll_value, roll_sides,
    input  rnd_ack, rnd_data
  );

  modport slave (
    input  rnd_req, busy, roll_valid, roll_value, roll_sides,
    output rnd_ack, rnd_data
  );
endinterface
`default_nettype wire

// File: rtl/dice_roll_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dice_roll_sequencer
// Brief  : Button conditioning, arbitration and roll sequencing for the dice roller.
// Rev    : 1.0 - initial release
// ============================================================================
module dice_roll_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RND_W           = 8
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic [5:0]           btn,
  input  wire logic                 switch_test,
  dice_roll_sequencer_if.master     bus
);

  localparam int         c_CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_REQ    = 2'd1;
  localparam logic [1:0] c_REDUCE = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [5:0]       r_btnMeta;
  logic [5:0]       r_btnSync;
  logic [5:0]       w_debLevel;
  logic [5:0]       r_debDly;
  logic [5:0]       w_event;
  logic             w_hit;
  logic [4:0]       w_sides;

  logic [1:0]       r_state;
  logic [4:0]       r_sides;
  logic             r_testMode;
  logic [RND_W-1:0] r_rem;
  logic [RND_W-1:0] w_sidesExt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btnMeta <= '0;
      r_btnSync <= '0;
      r_debDly  <= '0;
    end else begin
      r_btnMeta <= btn;
      r_btnSync <= r_btnMeta;
      r_debDly  <= w_debLevel;
    end
  end

  // Level is accepted only after it has disagreed for DEBOUNCE_CYCLES straight cycles.
  for (genvar i = 0; i < 6; i++) begin : g_debounce
    logic [c_CW-1:0] r_cnt;
    logic            r_deb;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else if (r_btnSync[i] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_cnt <= '0;
        r_deb <= r_btnSync[i];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_debLevel[i] = r_deb;
  end

  assign w_event = w_debLevel & ~r_debDly;

  // Lowest button index wins when several presses land together.
  always_comb begin
    w_hit   = |w_event;
    w_sides = 5'd0;
    if      (w_event[0]) w_sides = 5'd4;
    else if (w_event[1]) w_sides = 5'd6;
    else if (w_event[2]) w_sides = 5'd8;
    else if (w_event[3]) w_sides = 5'd10;
    else if (w_event[4]) w_sides = 5'd12;
    else if (w_event[5]) w_sides = 5'd20;
  end

  assign w_sidesExt = RND_W'(r_sides);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= c_IDLE;
      r_sides        <= 5'd0;
      r_testMode     <= 1'b0;
      r_rem          <= '0;
      bus.rnd_req    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.roll_valid <= 1'b0;
      bus.roll_value <= 5'd0;
      bus.roll_sides <= 5'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_hit) begin
            r_sides    <= w_sides;
            r_testMode <= switch_test;
            bus.busy   <= 1'b1;
            if (switch_test) begin
              // sides-1 reduces to the top face in a single pass
              r_rem   <= RND_W'(w_sides - 5'd1);
              r_state <= c_REDUCE;
            end else begin
              bus.rnd_req <= 1'b1;
              r_state     <= c_REQ;
            end
          end
        end
        c_REQ: begin
          if (bus.rnd_ack) begin
            bus.rnd_req <= 1'b0;
            r_rem       <= bus.rnd_data;
            r_state     <= c_REDUCE;
          end
        end
        c_REDUCE: begin
          if (r_rem >= w_sidesExt) begin
            r_rem <= r_rem - w_sidesExt;
          end else begin
            bus.roll_value <= r_rem[4:0] + 5'd1;
            bus.roll_sides <= r_sides;
            bus.roll_valid <= 1'b1;
            r_state        <= c_DONE;
          end
        end
        default: begin
          bus.roll_valid <= 1'b0;
          bus.busy       <= 1'b0;
          r_state        <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dice_roll_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_dice_roll_sequencer
// Brief  : Directed scoreboard bench for dice_roll_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dice_roll_sequencer;

  localparam int ACK_DELAY = 3;

  typedef struct {
    int value;
    int sides;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [5:0] btn;
  logic       switch_test;

  dice_roll_sequencer_if #(.RND_W(8)) bus ();

  dice_roll_sequencer #(
    .DEBOUNCE_CYCLES(16),
    .RND_W          (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn        (btn),
    .switch_test(switch_test),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checkCnt = 0;
  int   passCnt  = 0;
  int   failCnt  = 0;

  logic       ackEn    = 1'b1;
  logic       forceAck = 1'b0;
  logic [7:0] nextRnd  = 8'd0;
  int         ackWait  = 0;

  int   cycle       = 0;
  int   reqEpisodes = 0;
  int   rolls       = 0;
  int   busyRise    = 0;
  int   lastLatency = -1;
  int   reduceCnt   = 0;
  int   lastReduce  = -1;
  logic counting    = 1'b0;
  logic reqPrev     = 1'b0;
  logic busyPrev    = 1'b0;
  logic busySeen    = 1'b0;

  task automatic check(input string tag, input int observed, input int expected);
    checkCnt++;
    assert (observed === expected) begin
      passCnt++;
    end else begin
      failCnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Random source: acks ACK_DELAY cycles into each request.
  always @(posedge clk) begin
    #1;
    bus.rnd_ack = forceAck;
    if (ackEn && bus.rnd_req) begin
      if (ackWait == ACK_DELAY - 1) begin
        bus.rnd_ack  = 1'b1;
        bus.rnd_data = nextRnd;
        ackWait      = 0;
      end else begin
        ackWait++;
      end
    end else begin
      ackWait = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (bus.busy) busySeen = 1'b1;
    if (bus.rnd_req && !reqPrev) reqEpisodes++;
    reqPrev = bus.rnd_req;
    if (bus.busy && !busyPrev) busyRise = cycle;
    busyPrev = bus.busy;
    if (bus.rnd_ack && bus.rnd_req) begin
      counting  = 1'b1;
      reduceCnt = 0;
    end else if (bus.roll_valid) begin
      if (counting) lastReduce = reduceCnt;
      counting = 1'b0;
    end else if (counting) begin
      reduceCnt++;
    end
    if (bus.roll_valid) begin
      rolls++;
      lastLatency = cycle - busyRise;
      if (sb.size() == 0) begin
        check("unexpected_roll", 1, 0);
      end else begin
        e = sb.pop_front();
        check("roll_value", int'(bus.roll_value), e.value);
        check("roll_sides", int'(bus.roll_sides), e.sides);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle();
    int k = 0;
    while ((bus.busy || sb.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) check("idle_timeout", 0, 1);
  endtask

  task automatic waitBusy();
    int k = 0;
    while (!bus.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("busy_timeout", 0, 1);
  endtask

  initial begin
    int reqBase;
    int rollBase;
    int k;

    reset_n     = 1'b0;
    btn         = 6'b0;
    switch_test = 1'b0;
    waitCycles(3);
    check("rst_rnd_req",    int'(bus.rnd_req),    0);
    check("rst_busy",       int'(bus.busy),       0);
    check("rst_roll_valid", int'(bus.roll_valid), 0);
    check("rst_roll_value", int'(bus.roll_value), 0);
    check("rst_roll_sides", int'(bus.roll_sides), 0);
    reset_n = 1'b1;
    waitCycles(3);

    // D8 held 40 cycles, source returns 29 -> face 6
    reqBase = reqEpisodes; rollBase = rolls;
    nextRnd = 8'd29;
    sb.push_back('{6, 8});
    btn[2] = 1'b1;
    waitCycles(40);
    waitIdle();
    check("d8_req_episodes", reqEpisodes - reqBase, 1);
    check("d8_reduce_cycles", lastReduce, 4);
    waitCycles(20);
    check("d8_rolls_while_held", rolls - rollBase, 1);
    btn[2] = 1'b0;
    waitCycles(30);

    // D6 and D20 together: D6 wins, D20 dropped
    rollBase = rolls;
    nextRnd = 8'd5;
    sb.push_back('{6, 6});
    btn = 6'b100010;
    waitCycles(40);
    waitIdle();
    btn[1] = 1'b0;
    waitCycles(40);
    check("d20_dropped", rolls - rollBase, 1);
    btn[5] = 1'b0;
    waitCycles(30);
    sb.push_back('{6, 20});
    btn[5] = 1'b1;
    waitCycles(40);
    waitIdle();
    check("d20_repress", rolls - rollBase, 2);
    btn[5] = 1'b0;
    waitCycles(30);

    // test mode D20: no request, top face, one REDUCE cycle
    reqBase = reqEpisodes; rollBase = rolls;
    switch_test = 1'b1;
    sb.push_back('{20, 20});
    btn[5] = 1'b1;
    waitCycles(40);
    waitIdle();
    check("test_no_req", reqEpisodes - reqBase, 0);
    check("test_latency", lastLatency, 1);
    check("test_rolls", rolls - rollBase, 1);
    btn[5] = 1'b0;
    switch_test = 1'b0;
    waitCycles(30);

    // 5-cycle glitches never qualify
    reqBase = reqEpisodes; rollBase = rolls;
    busySeen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn[0] = 1'b1;
      waitCycles(5);
      btn[0] = 1'b0;
      waitCycles(5);
    end
    waitCycles(30);
    check("glitch_busy", int'(busySeen), 0);
    check("glitch_req", reqEpisodes - reqBase, 0);
    check("glitch_rolls", rolls - rollBase, 0);

    // D4 with 255: 64 REDUCE cycles; D12 pressed while busy is dropped
    rollBase = rolls;
    nextRnd = 8'd255;
    sb.push_back('{4, 4});
    btn[0] = 1'b1;
    waitBusy();
    btn[4] = 1'b1;
    waitIdle();
    check("d4_reduce_cycles", lastReduce, 64);
    waitCycles(40);
    check("d12_dropped", rolls - rollBase, 1);
    btn = 6'b0;
    waitCycles(30);

    // reset while in REQ, then a stray ack
    rollBase = rolls;
    ackEn = 1'b0;
    btn[3] = 1'b1;
    k = 0;
    while (!bus.rnd_req && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("req_reached", int'(bus.rnd_req), 1);
    reset_n = 1'b0;
    #1;
    check("abort_rnd_req",    int'(bus.rnd_req),    0);
    check("abort_busy",       int'(bus.busy),       0);
    check("abort_roll_value", int'(bus.roll_value), 0);
    btn = 6'b0;
    waitCycles(3);
    reset_n = 1'b1;
    reqBase = reqEpisodes;
    waitCycles(2);
    forceAck = 1'b1;
    waitCycles(1);
    forceAck = 1'b0;
    waitCycles(30);
    check("late_ack_rolls", rolls - rollBase, 0);
    check("late_ack_req", reqEpisodes - reqBase, 0);
    check("late_ack_busy", int'(bus.busy), 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
`default_nettype wire
